// File: rtl/fir_mac_tdm.sv
// Time-multiplexed FIR MAC: LANES products per cycle over TAPS/LANES cycles,
// with selectable round/truncate and saturate/wrap on the registered output.
module fir_mac_tdm #(
  parameter int DATA_WIDTH = 13,
  parameter int COEF_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int LANES      = 1,
  parameter int FRAC_BITS  = 12,
  parameter int OUT_WIDTH  = 13,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  VIN,
  output logic                  RDY_IN,
  input  logic                  COEF_WE,
  input  logic [AW-1:0]         COEF_ADDR,
  input  logic [COEF_WIDTH-1:0] COEF_DATA,
  input  logic                  RND_EN,
  input  logic                  SAT_EN,
  output logic [OUT_WIDTH-1:0]  DOUT,
  output logic                  VOUT,
  input  logic                  RDY_OUT,
  output logic                  OVF
);

  localparam int PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W = PW + $clog2(TAPS);
  // One guard bit so the rounding increment can never wrap the full sum.
  localparam int EW    = ACC_W + 1;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - LANES);
  localparam logic [AW-1:0] IDX_STEP = AW'(LANES);
  localparam logic signed [EW-1:0] OUT_MAX =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0] RND_ONE =
    (FRAC_BITS > 0) ? (EW'(1) << RND_SH) : EW'(0);
  localparam logic signed [EW-1:0] ZERO_E = EW'(0);

  logic [1:0]                   state_reg;
  logic [AW-1:0]                idx_reg;
  logic signed [ACC_W-1:0]      acc_reg;
  logic signed [ACC_W-1:0]      acc_next;
  logic                         rnd_reg;
  logic                         sat_reg;
  logic [OUT_WIDTH-1:0]         dout_reg;
  logic [OUT_WIDTH-1:0]         dout_next;
  logic                         vout_reg;
  logic                         ovf_reg;
  logic                         ovf_next;
  logic signed [EW-1:0]         rnd_sum;
  logic signed [EW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] x_reg [TAPS];
  logic signed [COEF_WIDTH-1:0] h_reg [TAPS];
  logic signed [PW-1:0]         prod  [LANES];
  logic                         accept;
  logic                         coef_wr;

  assign accept  = (state_reg == S_IDLE) && VIN;
  assign coef_wr = (state_reg == S_IDLE) && COEF_WE &&
                   ({1'b0, COEF_ADDR} < (AW+1)'(TAPS));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AW-1:0] tap;
    assign tap      = idx_reg + AW'(gi);
    assign prod[gi] = x_reg[tap] * h_reg[tap];
  end

  always_comb begin
    acc_next = acc_reg;
    for (int i = 0; i < LANES; i++) begin
      acc_next = acc_next + ACC_W'(prod[i]);
    end
    rnd_sum  = EW'(acc_next) + (rnd_reg ? RND_ONE : ZERO_E);
    shifted  = rnd_sum >>> FRAC_BITS;
    ovf_next = (shifted > OUT_MAX) || (shifted < OUT_MIN);
    if (sat_reg && ovf_next) begin
      dout_next = shifted[EW-1] ? OUT_MIN[OUT_WIDTH-1:0] : OUT_MAX[OUT_WIDTH-1:0];
    end else begin
      dout_next = shifted[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i] <= '0;
        h_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_reg[0] <= DIN;
        for (int i = 1; i < TAPS; i++) begin
          x_reg[i] <= x_reg[i-1];
        end
      end
      // A write on the accept edge lands before the first MAC cycle reads it.
      if (coef_wr) begin
        h_reg[COEF_ADDR] <= COEF_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      acc_reg   <= '0;
      rnd_reg   <= 1'b0;
      sat_reg   <= 1'b0;
      dout_reg  <= '0;
      vout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (VIN) begin
            rnd_reg   <= RND_EN;
            sat_reg   <= SAT_EN;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= S_MAC;
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + IDX_STEP;
          if (idx_reg == LAST_IDX) begin
            dout_reg  <= dout_next;
            ovf_reg   <= ovf_next;
            vout_reg  <= 1'b1;
            state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          if (RDY_OUT) begin
            vout_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign RDY_IN = (state_reg == S_IDLE);
  assign DOUT   = dout_reg;
  assign VOUT   = vout_reg;
  assign OVF    = ovf_reg;

endmodule

// File: tb/tb_fir_mac_tdm.sv
// Scoreboard bench for fir_mac_tdm: three builds (Q0/L1, default Q12/L1, Q0/L4)
// share stimulus; each build only sees VIN when selected.
module tb_fir_mac_tdm;

  typedef struct packed {
    logic signed [12:0] d;
    logic               o;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [12:0] din = '0;
  logic               vin = 1'b0;
  logic [1:0]         sel = 2'd0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [12:0] coef_data = '0;
  logic               rnd_en = 1'b0;
  logic               sat_en = 1'b1;
  logic               rdy_out = 1'b1;

  logic [2:0]  vin_w;
  logic [2:0]  rdy_w;
  logic [2:0]  vout_w;
  logic [2:0]  ovf_w;
  logic [12:0] dout_w [3];

  int  n_cmp = 0;
  int  n_err = 0;
  time acc_time = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  assign vin_w = {3{vin}} & (3'b001 << sel);

  fir_mac_tdm #(.FRAC_BITS(0), .LANES(1)) u0 (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin_w[0]), .RDY_IN(rdy_w[0]),
    .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
    .RND_EN(rnd_en), .SAT_EN(sat_en), .DOUT(dout_w[0]), .VOUT(vout_w[0]),
    .RDY_OUT(rdy_out), .OVF(ovf_w[0]));

  fir_mac_tdm u1 (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin_w[1]), .RDY_IN(rdy_w[1]),
    .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
    .RND_EN(rnd_en), .SAT_EN(sat_en), .DOUT(dout_w[1]), .VOUT(vout_w[1]),
    .RDY_OUT(rdy_out), .OVF(ovf_w[1]));

  fir_mac_tdm #(.FRAC_BITS(0), .LANES(4)) u2 (
    .CLK(clk), .RST_n(rst_n), .DIN(din), .VIN(vin_w[2]), .RDY_IN(rdy_w[2]),
    .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
    .RND_EN(rnd_en), .SAT_EN(sat_en), .DOUT(dout_w[2]), .VOUT(vout_w[2]),
    .RDY_OUT(rdy_out), .OVF(ovf_w[2]));

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_port(input int i, input logic [12:0] d, input logic o);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_cmp++;
    if (!have) begin
      n_err++;
      $display("FAIL out%0d unexpected output dout=%0d ovf=%0b", i, $signed(d), o);
    end else if ($signed(d) != e.d || o != e.o) begin
      n_err++;
      $display("FAIL out%0d dout=%0d ovf=%0b, required dout=%0d ovf=%0b",
               i, $signed(d), o, e.d, e.o);
    end else begin
      $display("out%0d dout=%0d ovf=%0b ok", i, $signed(d), o);
    end
  endtask

  // Monitor: one pop per output handshake, independent of stimulus.
  always @(negedge clk) begin
    if (rst_n && rdy_out) begin
      for (int i = 0; i < 3; i++) begin
        if (vout_w[i]) check_port(i, dout_w[i], ovf_w[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int k;
    k = 0;
    while (!rdy_w[i] && k < 200) begin
      tick();
      k++;
    end
    if (!rdy_w[i]) check($sformatf("rdy_in%0d timeout", i), 0, 1);
  endtask

  task automatic write_coef(input int a, input int d);
    int k;
    k = 0;
    while (rdy_w != 3'b111 && k < 200) begin
      tick();
      k++;
    end
    if (rdy_w != 3'b111) check("all idle timeout", int'(rdy_w), 7);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 13'(d);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic send(input int i, input int d, input bit rnd, input bit sat,
                      input int ed, input bit eo, input int lat);
    exp_t e;
    int   k;
    e.d = 13'(ed);
    e.o = eo;
    push_exp(i, e);
    sel    = 2'(i);
    din    = 13'(d);
    rnd_en = rnd;
    sat_en = sat;
    wait_idle(i);
    vin = 1'b1;
    @(posedge clk);
    acc_time = $time;
    #1;
    vin = 1'b0;
    // Modes must have been captured at acceptance, not sampled later.
    rnd_en = ~rnd;
    sat_en = ~sat;
    k = 0;
    while (!vout_w[i] && k < 64) begin
      tick();
      k++;
    end
    check($sformatf("latency%0d", i), k, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time prev;
    prev = 0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset dout%0d", i), $signed(dout_w[i]), 0);
      check($sformatf("reset vout%0d", i), int'(vout_w[i]), 0);
      check($sformatf("reset ovf%0d", i), int'(ovf_w[i]), 0);
      check($sformatf("reset rdy_in%0d", i), int'(rdy_w[i]), 1);
    end
    rst_n = 1'b1;
    tick();

    // Impulse through h[k]=k+1, Q0, one lane.
    for (int k = 0; k < 8; k++) write_coef(k, k + 1);
    for (int k = 0; k < 8; k++) begin
      send(0, (k == 0) ? 1 : 0, 1'b0, 1'b1, k + 1, 1'b0, 8);
      if (k > 0) check("spacing0", int'((acc_time - prev) / 10), 10);
      prev = acc_time;
    end

    // Same impulse on the four-lane build.
    for (int k = 0; k < 8; k++) begin
      send(2, (k == 0) ? 1 : 0, 1'b0, 1'b1, k + 1, 1'b0, 2);
      if (k > 0) check("spacing2", int'((acc_time - prev) / 10), 4);
      prev = acc_time;
    end

    // Rounding, Q12: h[0]=0.5.
    write_coef(0, 2048);
    for (int k = 1; k < 8; k++) write_coef(k, 0);
    send(1,  3, 1'b0, 1'b1,  1, 1'b0, 8);
    send(1,  3, 1'b1, 1'b1,  2, 1'b0, 8);
    send(1, -3, 1'b0, 1'b1, -2, 1'b0, 8);
    send(1, -3, 1'b1, 1'b1, -1, 1'b0, 8);

    // Saturation and wrap, Q0, full-scale taps.
    for (int k = 0; k < 8; k++) write_coef(k, 4095);
    for (int k = 0; k < 8; k++) send(0, 4095, 1'b0, 1'b1, 4095, 1'b1, 8);
    send(0, 4095, 1'b0, 1'b0, 8, 1'b1, 8);
    for (int k = 1; k <= 8; k++) send(0, -4096, 1'b0, 1'b1, (k <= 3) ? 4095 : -4096, 1'b1, 8);

    // Backpressure on the Q12 build: h[0]=0.5, h[1]=0.25.
    write_coef(0, 2048);
    write_coef(1, 1024);
    for (int k = 2; k < 8; k++) write_coef(k, 0);
    rdy_out = 1'b0;
    send(1, 5, 1'b0, 1'b1, 1, 1'b0, 8);
    for (int c = 0; c < 5; c++) begin
      check("hold vout", int'(vout_w[1]), 1);
      check("hold dout", $signed(dout_w[1]), 1);
      check("hold ovf", int'(ovf_w[1]), 0);
      check("hold rdy_in", int'(rdy_w[1]), 0);
      vin       = 1'b1;
      din       = 13'sd1000;
      coef_we   = (c == 2);
      coef_addr = 3'd0;
      coef_data = 13'sd0;
      tick();
    end
    vin     = 1'b0;
    coef_we = 1'b0;
    rdy_out = 1'b1;
    tick();
    check("release vout", int'(vout_w[1]), 0);
    check("release rdy_in", int'(rdy_w[1]), 1);
    send(1, 7, 1'b1, 1'b1, 5, 1'b0, 8);

    // Asynchronous reset in the middle of a computation on the Q0 build.
    sel = 2'd0;
    din = 13'sd9;
    wait_idle(0);
    vin = 1'b1;
    tick();
    vin = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midreset dout", $signed(dout_w[0]), 0);
    check("midreset vout", int'(vout_w[0]), 0);
    check("midreset ovf", int'(ovf_w[0]), 0);
    check("midreset rdy_in", int'(rdy_w[0]), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 100, 1'b0, 1'b1, 0, 1'b0, 8);

    repeat (20) tick();
    check("leftover0", q0.size(), 0);
    check("leftover1", q1.size(), 0);
    check("leftover2", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
